// File: rtl/reg_scoreboard.sv
// reg_scoreboard: write-back enable decoder and pending-write tracker.
// Stalls issue on RAW/WAW hazards against in-flight destinations.
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_issue_valid,
  input  logic                i_issue_writes,
  input  logic [ADDR_W-1:0]   i_issue_dst,
  input  logic [ADDR_W-1:0]   i_issue_src_a,
  input  logic [ADDR_W-1:0]   i_issue_src_b,
  output logic                o_issue_ready,
  input  logic                i_wb_valid,
  input  logic [ADDR_W-1:0]   i_wb_addr,
  output logic [NUM_REGS-1:0] o_wr_en_mask,
  output logic [NUM_REGS-1:0] o_busy_mask,
  output logic [ADDR_W:0]     o_pending_cnt,
  output logic                o_wb_spurious
);

  // r0 sits at the MSB; out-of-range and hardwired r0 decode to zero
  function automatic logic [NUM_REGS-1:0] f_dec(
    input logic [ADDR_W-1:0] a
  );
    logic [NUM_REGS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) m[NUM_REGS-1-i] = 1'b1;
    end
    if (ZERO_REG != 0) m[NUM_REGS-1] = 1'b0;
    return m;
  endfunction

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] r_wr_en;
  logic [ADDR_W:0]     r_cnt;
  logic                r_spur;

  logic [NUM_REGS-1:0] w_dec_a;
  logic [NUM_REGS-1:0] w_dec_b;
  logic [NUM_REGS-1:0] w_dec_dst;
  logic [NUM_REGS-1:0] w_dec_wb;
  logic                w_raw_a;
  logic                w_raw_b;
  logic                w_waw;
  logic                w_accept;
  logic                w_wb_zero;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] w_wr_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic                w_spur_nxt;

  assign w_dec_a   = f_dec(i_issue_src_a);
  assign w_dec_b   = f_dec(i_issue_src_b);
  assign w_dec_dst = f_dec(i_issue_dst);
  assign w_dec_wb  = f_dec(i_wb_addr);

  // hazards look only at registered busy bits, no write-back bypass
  assign w_raw_a = |(w_dec_a & r_busy);
  assign w_raw_b = |(w_dec_b & r_busy);
  assign w_waw   = i_issue_writes & (|(w_dec_dst & r_busy));

  assign o_issue_ready = !(w_raw_a | w_raw_b | w_waw);
  assign w_accept      = i_issue_valid & o_issue_ready;

  assign w_wb_zero = (ZERO_REG != 0) && (i_wb_addr == '0);

  // next busy/enable/count/spurious; set beats a same-index clear
  always_comb begin
    w_set      = '0;
    w_clr      = '0;
    w_wr_nxt   = '0;
    w_cnt_nxt  = '0;
    w_spur_nxt = 1'b0;
    if (w_accept && i_issue_writes) w_set = w_dec_dst;
    if (i_wb_valid) begin
      w_clr      = w_dec_wb;
      w_wr_nxt   = w_dec_wb;
      w_spur_nxt = !w_wb_zero && !(|(w_dec_wb & r_busy));
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_wr_en <= '0;
      r_cnt   <= '0;
      r_spur  <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_wr_en <= w_wr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_spur  <= w_spur_nxt;
    end
  end

  assign o_busy_mask   = r_busy;
  assign o_wr_en_mask  = r_wr_en;
  assign o_pending_cnt = r_cnt;
  assign o_wb_spurious = r_spur;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: three configurations driven in lockstep,
// checked against an array-of-flags model through expectation queues.
module tb_reg_scoreboard;

  typedef struct packed {
    logic [7:0] busy;
    logic [7:0] wr;
    logic [3:0] cnt;
    logic       spur;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv = 1'b0;
  logic       iw = 1'b0;
  logic [2:0] idst = '0;
  logic [2:0] isa = '0;
  logic [2:0] isb = '0;
  logic       wbv = 1'b0;
  logic [2:0] wba = '0;

  logic [7:0] a_busy [3];
  logic [7:0] a_wr [3];
  logic [3:0] a_cnt [3];
  logic       a_spur [3];
  logic       a_rdy [3];
  logic [5:0] b6;
  logic [5:0] w6;

  int checks = 0;
  int failures = 0;

  exp_t q [3][$];

  bit mb [3][8];
  logic [7:0] m_wr [3];
  bit m_spur [3];
  int cfg_n [3] = '{8, 6, 8};
  bit cfg_z [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(8), .ADDR_W(3), .ZERO_REG(0)) u_d8 (
    .clk(clk), .rst_n(rst_n),
    .i_issue_valid(iv), .i_issue_writes(iw),
    .i_issue_dst(idst), .i_issue_src_a(isa), .i_issue_src_b(isb),
    .o_issue_ready(a_rdy[0]),
    .i_wb_valid(wbv), .i_wb_addr(wba),
    .o_wr_en_mask(a_wr[0]), .o_busy_mask(a_busy[0]),
    .o_pending_cnt(a_cnt[0]), .o_wb_spurious(a_spur[0])
  );

  reg_scoreboard #(.NUM_REGS(6), .ADDR_W(3), .ZERO_REG(0)) u_d6 (
    .clk(clk), .rst_n(rst_n),
    .i_issue_valid(iv), .i_issue_writes(iw),
    .i_issue_dst(idst), .i_issue_src_a(isa), .i_issue_src_b(isb),
    .o_issue_ready(a_rdy[1]),
    .i_wb_valid(wbv), .i_wb_addr(wba),
    .o_wr_en_mask(w6), .o_busy_mask(b6),
    .o_pending_cnt(a_cnt[1]), .o_wb_spurious(a_spur[1])
  );

  assign a_busy[1] = {2'b00, b6};
  assign a_wr[1]   = {2'b00, w6};

  reg_scoreboard #(.NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1)) u_dz (
    .clk(clk), .rst_n(rst_n),
    .i_issue_valid(iv), .i_issue_writes(iw),
    .i_issue_dst(idst), .i_issue_src_a(isa), .i_issue_src_b(isb),
    .o_issue_ready(a_rdy[2]),
    .i_wb_valid(wbv), .i_wb_addr(wba),
    .o_wr_en_mask(a_wr[2]), .o_busy_mask(a_busy[2]),
    .o_pending_cnt(a_cnt[2]), .o_wb_spurious(a_spur[2])
  );

  function automatic bit hard0(int c, int a);
    return cfg_z[c] && a == 0;
  endfunction

  function automatic bit m_isbusy(int c, int a);
    return a < cfg_n[c] && mb[c][a];
  endfunction

  function automatic logic [7:0] m_onehot(int c, int a);
    logic [7:0] m;
    m = '0;
    if (a < cfg_n[c] && !hard0(c, a)) m[cfg_n[c]-1-a] = 1'b1;
    return m;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 8; r++) mb[c][r] = 1'b0;
      m_wr[c] = '0;
      m_spur[c] = 1'b0;
    end
  endtask

  task automatic chk(string nm, int c, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg%0d got=%h want=%h at %0t", nm, c, act, exp, $time);
    end
  endtask

  // one cycle: apply inputs, queue expectations, advance model and clock
  task automatic cyc(input bit v, input bit w, input int d, input int sa,
                     input int sb, input bit wv, input int wa);
    exp_t e;
    bit rdy;
    bit sp;
    logic [7:0] wrn;
    iv = v; iw = w;
    idst = 3'(d); isa = 3'(sa); isb = 3'(sb);
    wbv = wv; wba = 3'(wa);
    for (int c = 0; c < 3; c++) begin
      rdy = !(m_isbusy(c, sa) || m_isbusy(c, sb) || (w && m_isbusy(c, d)));
      e.busy = '0;
      e.cnt = '0;
      for (int r = 0; r < cfg_n[c]; r++) begin
        if (mb[c][r]) begin
          e.busy[cfg_n[c]-1-r] = 1'b1;
          e.cnt = e.cnt + 4'd1;
        end
      end
      e.wr = m_wr[c];
      e.spur = m_spur[c];
      e.rdy = rdy;
      q[c].push_back(e);
      sp = wv && !m_isbusy(c, wa) && !hard0(c, wa);
      wrn = wv ? m_onehot(c, wa) : 8'h00;
      if (wv && wa < cfg_n[c]) mb[c][wa] = 1'b0;
      if (v && rdy && w && d < cfg_n[c] && !hard0(c, d)) mb[c][d] = 1'b1;
      m_wr[c] = wrn;
      m_spur[c] = sp;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv = 1'b0; iw = 1'b0; wbv = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  // monitor: pop one expectation per configuration each cycle
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      if (q[c].size() > 0) begin
        e = q[c].pop_front();
        chk("busy_mask", c, a_busy[c], e.busy);
        chk("wr_en_mask", c, a_wr[c], e.wr);
        chk("pending_cnt", c, {4'h0, a_cnt[c]}, {4'h0, e.cnt});
        chk("wb_spurious", c, {7'h0, a_spur[c]}, {7'h0, e.spur});
        chk("issue_ready", c, {7'h0, a_rdy[c]}, {7'h0, e.rdy});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_list [$];
    @(posedge clk);
    #1;
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 0, 0, 0);
    cyc(1, 0, 0, 3, 0, 1, 3);
    cyc(1, 0, 0, 3, 0, 0, 0);
    cyc(1, 1, 5, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 2, 0, 0);
    cyc(1, 0, 5, 1, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 5);
    cyc(1, 1, 6, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 1, 6);
    cyc(1, 1, 4, 0, 0, 1, 4);
    cyc(0, 0, 0, 0, 0, 1, 7);
    cyc(1, 1, 6, 0, 0, 0, 0);
    cyc(1, 1, 2, 7, 7, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int r = 0; r < 8; r++) cyc(1, 1, r, r, r, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 0, 1, 4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      int wa;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        busy_list.delete();
        for (int r = 0; r < 8; r++) if (mb[0][r]) busy_list.push_back(r);
        if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
          wa = busy_list[$urandom_range(0, busy_list.size() - 1)];
        else
          wa = $urandom_range(0, 7);
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1) == 1, wa);
      end
    end
    iv = 1'b0; wbv = 1'b0;
    @(negedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (q[c].size() != 0) begin
        failures++;
        $display("FAIL drain cfg%0d left=%0d want=0", c, q[c].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
